// File: rtl/keypad_pkg.sv
// Shared types and tables for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // One-hot-low pattern per index: used both as column drive and as the
  // expected row reading for a latched row.
  localparam logic [3:0][3:0] ONE_LOW = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  localparam logic [3:0] ROWS_IDLE = 4'b1111;

  // Row encoder result layout: {hit, idx[1:0]}; hit only for exactly one low row.
  localparam logic       ROW_HIT  = 1'b1;
  localparam logic [2:0] ROW_NONE = 3'b000;

  function automatic logic [2:0] row_encode(input logic [3:0] rows);
    case (rows)
      4'b1110: row_encode = {ROW_HIT, 2'd0};
      4'b1101: row_encode = {ROW_HIT, 2'd1};
      4'b1011: row_encode = {ROW_HIT, 2'd2};
      4'b0111: row_encode = {ROW_HIT, 2'd3};
      default: row_encode = ROW_NONE;
    endcase
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// 4-bit two-flop synchronizer for the asynchronous keypad rows.
// Resets to all-high (no key closed).
module keypad_row_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  // Two-stage capture of the raw pulled-up row lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 4'b1111;
      q    <= 4'b1111;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column scan, single-key debounce, press strobe and
// held flag. Optional auto-repeat under macro KEYPAD_AUTOREPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int REPEAT_CYCLES   = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DB_LAST  = BW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    rows_s;
  state_t        state, state_n;
  logic [DW-1:0] div_cnt, div_n;
  logic [BW-1:0] db_cnt, db_n;
  logic [1:0]    col_idx, col_n;
  logic [1:0]    row_idx, row_n;
  logic [3:0]    code_n;
  logic          valid_n, held_n;
  logic [2:0]    hit;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);
  localparam logic [RW-1:0] REP_LAST      = RW'(REPEAT_CYCLES - 1);
  localparam logic [RW-1:0] REP_FAST_LAST = RW'(REPEAT_CYCLES / 4 - 1);
  logic [RW-1:0] rep_cnt, rep_n;
  logic          rep_fast, fast_n;
`endif

  keypad_row_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row_in),
    .q     (rows_s)
  );

  // Next-state and next-output logic for scan/debounce/press/release.
  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    db_n    = db_cnt;
    col_n   = col_idx;
    row_n   = row_idx;
    code_n  = key_code;
    valid_n = 1'b0;
    held_n  = key_held;
    hit     = row_encode(rows_s);
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_n   = rep_cnt;
    fast_n  = rep_fast;
`endif
    case (state)
      SCAN: begin
        if (div_cnt == DIV_LAST) begin
          div_n = '0;
          if (hit[2]) begin
            // Column stays frozen while the candidate key is debounced.
            row_n   = hit[1:0];
            db_n    = '0;
            state_n = DEBOUNCE;
          end else begin
            col_n = col_idx + 2'd1;
          end
        end else begin
          div_n = div_cnt + DW'(1);
        end
      end
      DEBOUNCE: begin
        if (rows_s != ONE_LOW[row_idx]) begin
          db_n    = '0;
          col_n   = col_idx + 2'd1;
          state_n = SCAN;
        end else if (db_cnt == DB_LAST) begin
          db_n    = '0;
          code_n  = {row_idx, col_idx};
          valid_n = 1'b1;
          held_n  = 1'b1;
          state_n = PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
          rep_n   = '0;
          fast_n  = 1'b0;
`endif
        end else begin
          db_n = db_cnt + BW'(1);
        end
      end
      PRESSED: begin
        // Only the latched row matters; other keys are ignored here.
        if (rows_s[row_idx]) begin
          db_n    = '0;
          state_n = RELEASE;
`ifdef KEYPAD_AUTOREPEAT_EN
          rep_n   = '0;
          fast_n  = 1'b0;
`endif
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        else if (rep_cnt == (rep_fast ? REP_FAST_LAST : REP_LAST)) begin
          valid_n = 1'b1;
          rep_n   = '0;
          fast_n  = 1'b1;
        end else begin
          rep_n = rep_cnt + RW'(1);
        end
`endif
      end
      RELEASE: begin
        if (!rows_s[row_idx]) begin
          db_n    = '0;
          state_n = PRESSED;
        end else if (rows_s != ROWS_IDLE) begin
          // Some other key is down: wait for a fully idle keypad.
          db_n = '0;
        end else if (db_cnt == DB_LAST) begin
          db_n    = '0;
          held_n  = 1'b0;
          col_n   = col_idx + 2'd1;
          state_n = SCAN;
        end else begin
          db_n = db_cnt + BW'(1);
        end
      end
      default: state_n = SCAN;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      div_cnt   <= '0;
      db_cnt    <= '0;
      col_idx   <= 2'd0;
      row_idx   <= 2'd0;
      col_out   <= ONE_LOW[0];
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt   <= '0;
      rep_fast  <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      div_cnt   <= div_n;
      db_cnt    <= db_n;
      col_idx   <= col_n;
      row_idx   <= row_n;
      col_out   <= ONE_LOW[col_n];
      key_code  <= code_n;
      key_valid <= valid_n;
      key_held  <= held_n;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt   <= rep_n;
      rep_fast  <= fast_n;
`endif
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model (pressed-key mask
// shorted onto driven columns) and expectations from the timing rules.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 8;
  localparam int RP = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row_in, col_out, key_code;
  logic        key_valid, key_held;
  logic [15:0] keys = '0;   // bit r*4+c set = key (r,c) closed
  int          checks = 0;
  int          passed = 0;
  int          nvalid = 0;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(RP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // A row is pulled low when any closed key on it sits in a driven column.
  always_comb begin
    row_in = 4'b1111;
    for (int r = 0; r < 4; r++)
      row_in[r] = ~|(keys[r*4 +: 4] & ~col_out);
  end

  always @(negedge clk) if (rst_n && key_valid) nvalid++;

  function automatic logic [3:0] drive(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << c);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (col_out !== 4'b1110) $display("FAIL reset_col got=%b exp=1110", col_out); else passed++;
    checks++; if (key_code !== 4'h0) $display("FAIL reset_code got=%h exp=0", key_code); else passed++;
    checks++; if (key_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", key_valid); else passed++;
    checks++; if (key_held !== 1'b0) $display("FAIL reset_held got=%b exp=0", key_held); else passed++;
  endtask

  task automatic test_idle();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (col_out !== drive((i / SD) % 4)) $display("FAIL idle_col[%0d] got=%b exp=%b", i, col_out, drive((i / SD) % 4));
      else passed++;
      checks++;
      if (key_valid !== 1'b0) $display("FAIL idle_valid[%0d] got=%b exp=0", i, key_valid); else passed++;
      @(negedge clk);
    end
  endtask

  // Press (r,c) just before its column comes round, hold, release, and
  // check press latency, code, held flag, single strobe and release latency.
  task automatic press_and_check(input int r, input int c, input int hold);
    int n, v0;
    logic [3:0] exp;
    exp = 4'(r * 4 + c);
    n = 0;
    while (col_out !== drive((c + 1) % 4) && n < 64) begin @(negedge clk); n++; end
    keys[r*4 + c] = 1'b1;
    v0 = nvalid;
    n = 0;
    while (col_out !== drive(c) && n < 64) begin @(negedge clk); n++; end
    n = 0;
    while (key_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++; if (n != SD + DB) $display("FAIL press_latency key=%h got=%0d exp=%0d", exp, n, SD + DB); else passed++;
    checks++; if (key_code !== exp) $display("FAIL press_code got=%h exp=%h", key_code, exp); else passed++;
    checks++; if (key_held !== 1'b1) $display("FAIL press_held key=%h got=%b exp=1", exp, key_held); else passed++;
    @(negedge clk);
    checks++; if (key_valid !== 1'b0) $display("FAIL valid_width key=%h got=%b exp=0", exp, key_valid); else passed++;
    repeat (hold) @(negedge clk);
    checks++; if (key_held !== 1'b1) $display("FAIL hold_held key=%h got=%b exp=1", exp, key_held); else passed++;
    keys[r*4 + c] = 1'b0;
    n = 0;
    while (key_held !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    // DB+1 after rows_s goes high, plus the two synchronizer stages.
    checks++; if (n != DB + 3) $display("FAIL release_latency key=%h got=%0d exp=%0d", exp, n, DB + 3); else passed++;
    checks++; if (nvalid - v0 != 1) $display("FAIL press_pulses key=%h got=%0d exp=1", exp, nvalid - v0); else passed++;
    checks++; if (key_code !== exp) $display("FAIL code_kept got=%h exp=%h", key_code, exp); else passed++;
  endtask

  task automatic test_clean_press();
    press_and_check(2, 1, 40);
  endtask

  task automatic test_random_press();
    for (int k = 0; k < 6; k++)
      press_and_check(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(5, 40)));
  endtask

  task automatic test_bounce();
    int n, v0;
    n = 0;
    while (col_out !== drive(2) && n < 64) begin @(negedge clk); n++; end
    v0 = nvalid;
    for (int i = 0; i < 10; i++) begin
      keys[3] = ~keys[3];
      repeat (3) @(negedge clk);
    end
    checks++; if (nvalid != v0) $display("FAIL bounce_quiet got=%0d exp=0", nvalid - v0); else passed++;
    keys[3] = 1'b1;
    n = 0;
    while (key_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++; if (key_code !== 4'h3) $display("FAIL bounce_code got=%h exp=3", key_code); else passed++;
    @(negedge clk);
    checks++; if (nvalid - v0 != 1) $display("FAIL bounce_pulses got=%0d exp=1", nvalid - v0); else passed++;
    keys[3] = 1'b0;
    n = 0;
    while (key_held !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    checks++; if (key_held !== 1'b0) $display("FAIL bounce_release got=%b exp=0", key_held); else passed++;
  endtask

  task automatic test_multi_key();
    int v0;
    logic [3:0] seen;
    seen = '0;
    v0 = nvalid;
    keys[0] = 1'b1;
    keys[4] = 1'b1;
    repeat (64) begin
      @(negedge clk);
      seen = seen | ~col_out;
    end
    checks++; if (nvalid != v0) $display("FAIL multi_valid got=%0d exp=0", nvalid - v0); else passed++;
    checks++; if (seen !== 4'hF) $display("FAIL multi_scan got=%b exp=1111", seen); else passed++;
    checks++; if (key_held !== 1'b0) $display("FAIL multi_held got=%b exp=0", key_held); else passed++;
    keys = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_pressed();
    int n;
    keys[6] = 1'b1;   // key (1,2)
    n = 0;
    while (key_held !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    checks++; if (key_code !== 4'h6) $display("FAIL pre_reset_code got=%h exp=6", key_code); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if (col_out !== 4'b1110) $display("FAIL midreset_col got=%b exp=1110", col_out); else passed++;
    checks++; if (key_held !== 1'b0) $display("FAIL midreset_held got=%b exp=0", key_held); else passed++;
    checks++; if (key_code !== 4'h0) $display("FAIL midreset_code got=%h exp=0", key_code); else passed++;
    keys = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_autorepeat();
    int n;
    int got[$];
    int exp[$];
    keys[15] = 1'b1;
    n = 0;
    while (key_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (key_valid === 1'b1) got.push_back(i);
    end
`ifdef KEYPAD_AUTOREPEAT_EN
    for (int off = RP; off <= 200; off += RP / 4) exp.push_back(off);
`endif
    checks++;
    if (got.size() != exp.size()) $display("FAIL repeat_count got=%0d exp=%0d", got.size(), exp.size());
    else passed++;
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      checks++;
      if (got[i] != exp[i]) $display("FAIL repeat_offset[%0d] got=%0d exp=%0d", i, got[i], exp[i]);
      else passed++;
    end
    checks++; if (key_code !== 4'hF) $display("FAIL repeat_code got=%h exp=f", key_code); else passed++;
    keys = '0;
    n = 0;
    while (key_held !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    checks++; if (key_held !== 1'b0) $display("FAIL repeat_release got=%b exp=0", key_held); else passed++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_idle();
    test_clean_press();
    test_random_press();
    test_bounce();
    test_multi_key();
    test_reset_pressed();
    test_autorepeat();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
